// File: rtl/control_sequencer_pkg.sv
// sap1_pkg: opcodes, control-word field positions and T-state encoding shared by
// the SAP-1 sequencer, bus registers and datapath top.
package sap1_pkg;
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam int CP   = 11;
    localparam int EP   = 10;
    localparam int LM_N = 9;
    localparam int CE_N = 8;
    localparam int LI_N = 7;
    localparam int EI_N = 6;
    localparam int LA_N = 5;
    localparam int EA   = 4;
    localparam int SU   = 3;
    localparam int EU   = 2;
    localparam int LB_N = 1;
    localparam int LO_N = 0;
    localparam logic [11:0] CON_IDLE = 12'h3E3;
    // Each active word is the idle word with its asserted fields flipped.
    localparam logic [11:0] CON_T1   = CON_IDLE ^ (12'(1) << EP) ^ (12'(1) << LM_N);
    localparam logic [11:0] CON_T2   = CON_IDLE ^ (12'(1) << CP);
    localparam logic [11:0] CON_T3   = CON_IDLE ^ (12'(1) << CE_N) ^ (12'(1) << LI_N);
    localparam logic [11:0] CON_MAR4 = CON_IDLE ^ (12'(1) << EI_N) ^ (12'(1) << LM_N);
    localparam logic [11:0] CON_OUT4 = CON_IDLE ^ (12'(1) << EA) ^ (12'(1) << LO_N);
    localparam logic [11:0] CON_LDA5 = CON_IDLE ^ (12'(1) << CE_N) ^ (12'(1) << LA_N);
    localparam logic [11:0] CON_B5   = CON_IDLE ^ (12'(1) << CE_N) ^ (12'(1) << LB_N);
    localparam logic [11:0] CON_ADD6 = CON_IDLE ^ (12'(1) << LA_N) ^ (12'(1) << EU);
    localparam logic [11:0] CON_SUB6 = CON_ADD6 ^ (12'(1) << SU);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: run/opcode inputs and control-word/T-state/halt outputs of
// the sequencer; master is the sequencer, slave is the datapath side.
interface control_sequencer_if;
    logic        RUN;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        HLT;
    modport master (input RUN, opcode, output con, t_state, HLT);
    modport slave  (output RUN, opcode, input con, t_state, HLT);
endinterface

// File: rtl/control_sequencer_ring_counter.sv
// ring_counter: six-state one-hot T-state ring with enable, sync clear and early return.
module ring_counter
    import sap1_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en_i,
    input  logic     early_i,
    output t_state_e t_o
);
    t_state_e t_q, t_d;
    always_comb begin
        t_d = ($onehot(t_q) && !en_i) ? t_q : T1;
        if (en_i && !early_i)
            case (t_q)
                T1:      t_d = T2;
                T2:      t_d = T3;
                T3:      t_d = T4;
                T4:      t_d = T5;
                T5:      t_d = T6;
                default: t_d = T1;
            endcase
    end
    always_ff @(posedge clk)
        t_q <= rst ? T1 : t_d;
    assign t_o = t_q;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: SAP-1 controller; decodes opcode and T-state into the
// 12-bit control word and latches the halt flag.
module control_sequencer
    import sap1_pkg::*;
#(
    parameter bit EARLY_END = 1'b0
) (
    input  logic CLK,
    input  logic CLR,
    control_sequencer_if.master bus
);
    t_state_e t;
    logic     hlt_q, hlt_d, halting, is_nop, early, en;
    assign halting = bus.RUN && !hlt_q && t == T4 && bus.opcode == OP_HLT;
    assign is_nop  = !(bus.opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});
    assign early   = EARLY_END && ((t == T5 && bus.opcode == OP_LDA) ||
                                   (t == T4 && bus.opcode == OP_OUT) ||
                                   (t == T3 && is_nop));
    assign en      = bus.RUN && !hlt_q && !halting;
    assign hlt_d   = hlt_q || halting;
    ring_counter u_ring (
        .clk     (CLK),
        .rst     (CLR),
        .en_i    (en),
        .early_i (early),
        .t_o     (t)
    );
    always_ff @(posedge CLK)
        hlt_q <= CLR ? 1'b0 : hlt_d;
    // Gating on RUN keeps a stalled state from re-issuing its pulse (e.g. Cp).
    always_comb begin
        bus.con = CON_IDLE;
        if (!CLR && bus.RUN && !hlt_q)
            case (t)
                T1: bus.con = CON_T1;
                T2: bus.con = CON_T2;
                T3: bus.con = CON_T3;
                T4: bus.con = (bus.opcode == OP_OUT) ? CON_OUT4 :
                              (bus.opcode inside {OP_LDA, OP_ADD, OP_SUB}) ? CON_MAR4 : CON_IDLE;
                T5: bus.con = (bus.opcode == OP_LDA) ? CON_LDA5 :
                              (bus.opcode inside {OP_ADD, OP_SUB}) ? CON_B5 : CON_IDLE;
                T6: bus.con = (bus.opcode == OP_ADD) ? CON_ADD6 :
                              (bus.opcode == OP_SUB) ? CON_SUB6 : CON_IDLE;
                default: bus.con = CON_IDLE;
            endcase
    end
    assign bus.t_state = t;
    assign bus.HLT     = hlt_q;
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
SAP-1 controller-sequencer: the initiating end of the control-word interface that every bus register (B, A, MAR, IR, OUT) responds to.
- Six-state one-hot ring counter (T1..T6).
- Decodes the IR opcode nibble and drives the 12-bit active-mixed control word each T-state.
- Raises HLT on the halt opcode.
- Sits between the instruction register and all W-bus load/enable pins.

Parameters:
EARLY_END, 0, when 1 the sequence returns to T1 right after the last T-state that issues a non-idle control word (LDA after T5, OUT after T4, NOP after T3); when 0 all instructions take T1..T6.

Ports:
CLK  input  1  system clock, all state changes on posedge
CLR  input  1  synchronous active-high reset
RUN  input  1  1 = advance one T-state per clock; 0 = hold state, control word forced inactive
opcode  input  4  IR upper nibble, must be stable from T4 through end of instruction
con  output  12  control word {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar} (bit 11..0)
t_state  output  6  one-hot current T-state, bit0 = T1
HLT  output  1  halted flag, registered

Behaviour:
- Reset: CLR sampled on posedge; next state is t_state=6'b000001, HLT=0.
- While CLR=1, con=CON_IDLE (12'h3E3) combinationally, regardless of state.
- con is combinational from registered t_state, opcode, HLT, RUN and CLR. It is valid for the whole cycle. Responders capture it at the posedge that ends the cycle, which is the same edge where t_state advances. Latency 0.
- RUN=0: t_state and HLT hold; con=CON_IDLE. No control pulse may repeat, so Cp never increments PC twice.
- Fetch, all opcodes:
  - T1 = Ep, Lm_bar=0 → 12'h5E3
  - T2 = Cp → 12'hBE3
  - T3 = CE_bar=0, Li_bar=0 → 12'h263
- LDA (4'h0):
  - T4 Ei_bar=0, Lm_bar=0 → 12'h1A3
  - T5 CE_bar=0, La_bar=0 → 12'h2C3
  - T6 idle
- ADD (4'h1):
  - T4 12'h1A3
  - T5 CE_bar=0, Lb_bar=0 → 12'h2E1
  - T6 La_bar=0, Eu → 12'h3C7
- SUB (4'h2): same as ADD, but T6 also asserts Su → 12'h3CF.
- OUT (4'hE):
  - T4 Ea, Lo_bar=0 → 12'h3F2
  - T5, T6 idle
- HLT (4'hF): in T4 with RUN=1, the next posedge sets HLT=1 and t_state stays T4. con=CON_IDLE during that T4 cycle and for as long as HLT=1. Only CLR clears HLT; RUN has no effect while halted.
- Undefined opcodes: treated as NOP, idle for T4..T6 (EARLY_END=1: return to T1 after T3).
- Ring advance: T6→T1 wraps. With EARLY_END=1, the early return is decided by the opcode sampled in the terminating T-state.
- t_state must always be exactly one-hot. Any illegal encoding recovers to T1 on the next posedge (default branch).
- CLR mid-instruction: abort immediately. Next cycle is T1 with no partial T4..T6 pulses.
- CLR and RUN both high: CLR wins.

Decomposition:
- Package sap1_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT
  - bit-index constants for the con fields
  - CON_IDLE = 12'h3E3
  - T-state one-hot typedef
- Shared with the register modules and datapath top.
- One sub-module: ring_counter (6-bit one-hot, RUN enable, synchronous clear, early-return input).
- Opcode/T-state decode stays in control_sequencer.

Test Plan:
- CLR=1 for 2 cycles then RUN=1, opcode=4'h0:
  - con sequence 5E3, BE3, 263, 1A3, 2C3, 3E3
  - t_state 01,02,04,08,10,20 then wraps to 01
- opcode=4'h2 (SUB), RUN=1: T4..T6 con = 1A3, 2E1, 3CF; Su only in T6.
- opcode=4'hF: after T3, T4 con=3E3. Next edge HLT=1, t_state=6'h08 frozen for 10 cycles with RUN toggling. CLR=1 → HLT=0, t_state=6'h01.
- RUN=0 asserted during T2:
  - con=3E3, t_state holds 6'h02 for 5 cycles
  - RUN=1 → single BE3 cycle, then 263
- EARLY_END=1, opcode=4'hE: T1..T4 then T1. Total 4 cycles per instruction; con at T4 = 3F2.
- CLR=1 during T5 of ADD: that cycle con=3E3; next cycle t_state=6'h01, con=5E3; no 2E1 or 3C7 emitted.
